alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_if.sv | 28 ++
 rtl/alu_core.sv | 87 ++++++++
 rtl/alu.sv | 61 ++++++
 tb/tb_alu.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings for the ALU datapath, its wrapper and the bench.
// Values 9..15 are reserved and produce an all-zero result.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        ADD_OP      = 4'd0,
        SUB_OP      = 4'd1,
        AND_OP      = 4'd2,
        OR_OP       = 4'd3,
        XOR_OP      = 4'd4,
        NOT_OP      = 4'd5,
        LL_SHIFT_OP = 4'd6,
        LR_SHIFT_OP = 4'd7,
        AR_SHIFT_OP = 4'd8
    } opcode_t;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/result bundle of the ALU.
// The master drives the operation; the slave returns the registered result and flags.
interface alu_if
    import alu_pkg::*;
#(
    parameter int N = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic [N-1:0]        a;
    logic [N-1:0]        b;
    logic                cin;
    logic [N-1:0]        y;
    logic                cout;
    logic                overflow;
    logic                negative;
    logic                zero;

    modport master (
        output opcode, a, b, cin,
        input  y, cout, overflow, negative, zero
    );

    modport slave (
        input  opcode, a, b, cin,
        output y, cout, overflow, negative, zero
    );

endinterface : alu_if

// File: rtl/alu_core.sv
// Purely combinational ALU datapath; the result flags are derived from the
// freshly computed y so the wrapper only has to register them.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [N-1:0]        a,
    input  logic [N-1:0]        b,
    input  logic                cin,
    output logic [N-1:0]        y,
    output logic                cout,
    output logic                overflow,
    output logic                negative,
    output logic                zero
);

    localparam logic [N:0] N_VAL = (N+1)'(N);

    logic [N-1:0] w_b_inv;
    logic [N:0]   w_add;
    logic [N:0]   w_sub;
    logic [N:0]   w_ll;
    logic [N:0]   w_lr;
    logic [N:0]   w_ar;
    logic         w_big_shift;

    assign w_b_inv = ~b;
    assign w_add   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign w_sub   = {1'b0, a} + {1'b0, w_b_inv} + {{N{1'b0}}, ~cin};

    // One spare bit catches the last bit shifted out: above the MSB for left
    // shifts, below the LSB for right shifts. A zero shift leaves it at 0.
    assign w_ll        = {1'b0, a} << b;
    assign w_lr        = {a, 1'b0} >> b;
    assign w_ar        = $signed({a, 1'b0}) >>> b;
    assign w_big_shift = ({1'b0, b} >= N_VAL);

    always_comb begin
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (opcode)
            ADD_OP: begin
                {cout, y} = w_add;
                overflow  = (a[N-1] == b[N-1]) && (w_add[N-1] != a[N-1]);
            end
            SUB_OP: begin
                {cout, y} = w_sub;
                overflow  = (a[N-1] == w_b_inv[N-1]) && (w_sub[N-1] != a[N-1]);
            end
            AND_OP: y = a & b;
            OR_OP:  y = a | b;
            XOR_OP: y = a ^ b;
            NOT_OP: y = ~a;
            LL_SHIFT_OP: begin
                if (!w_big_shift) begin
                    {cout, y} = w_ll;
                end
            end
            LR_SHIFT_OP: begin
                if (!w_big_shift) begin
                    {y, cout} = w_lr;
                end
            end
            AR_SHIFT_OP: begin
                // Oversized arithmetic shifts saturate to the sign bit everywhere.
                if (w_big_shift) begin
                    y    = {N{a[N-1]}};
                    cout = a[N-1];
                end else begin
                    {y, cout} = w_ar;
                end
            end
            default: begin
                y        = '0;
                cout     = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign negative = y[N-1];
    assign zero     = (y == '0);

endmodule : alu_core

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, a new operation accepted every clock.
// Reset forces an all-zero result, which reads back with zero=1.
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input logic   clk,
    input logic   rst,
    alu_if.slave  bus
);

    logic [N-1:0] w_y;
    logic         w_cout;
    logic         w_overflow;
    logic         w_negative;
    logic         w_zero;

    logic [N-1:0] r_y;
    logic         r_cout;
    logic         r_overflow;
    logic         r_negative;
    logic         r_zero;

    alu_core #(
        .N (N)
    ) u_core (
        .opcode   (bus.opcode),
        .a        (bus.a),
        .b        (bus.b),
        .cin      (bus.cin),
        .y        (w_y),
        .cout     (w_cout),
        .overflow (w_overflow),
        .negative (w_negative),
        .zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y        <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_negative <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_y        <= w_y;
            r_cout     <= w_cout;
            r_overflow <= w_overflow;
            r_negative <= w_negative;
            r_zero     <= w_zero;
        end
    end

    assign bus.y        = r_y;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
    assign bus.negative = r_negative;
    assign bus.zero     = r_zero;

endmodule : alu

// File: tb/tb_alu.sv
// Scoreboard bench for the 4-bit ALU: each issued operation queues its
// expected result, which is popped and compared one cycle later.
module tb_alu;
    import alu_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] y;
        logic         cout;
        logic         ovf;
        logic         neg;
        logic         zero;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    res_t exp_q[$];

    alu_if #(.N(N)) bus ();

    alu #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent integer reference model.
    function automatic res_t model(input logic [3:0] op, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic cin);
        res_t r;
        int ua, ub, sa, sb, s, ss;
        r  = '0;
        ua = int'(a);
        ub = int'(b);
        sa = a[N-1] ? ua - 16 : ua;
        sb = b[N-1] ? ub - 16 : ub;
        case (op)
            4'd0: begin
                s = ua + ub + int'(cin);
                ss = sa + sb + int'(cin);
                r.y = 4'(s);
                r.cout = (s >= 16);
                r.ovf = (ss > 7) || (ss < -8);
            end
            4'd1: begin
                s = ua - ub - int'(cin);
                ss = sa - sb - int'(cin);
                r.y = 4'(s);
                r.cout = (s >= 0);
                r.ovf = (ss > 7) || (ss < -8);
            end
            4'd2: r.y = a & b;
            4'd3: r.y = a | b;
            4'd4: r.y = a ^ b;
            4'd5: r.y = ~a;
            4'd6: if (ub < N) begin
                r.y = 4'(ua << ub);
                r.cout = (ub == 0) ? 1'b0 : 1'((ua >> (N - ub)) & 1);
            end
            4'd7: if (ub < N) begin
                r.y = 4'(ua >> ub);
                r.cout = (ub == 0) ? 1'b0 : 1'((ua >> (ub - 1)) & 1);
            end
            4'd8: begin
                if (ub >= N) begin
                    r.y = {N{a[N-1]}};
                    r.cout = a[N-1];
                end else begin
                    r.y = 4'(sa >>> ub);
                    r.cout = (ub == 0) ? 1'b0 : 1'((ua >> (ub - 1)) & 1);
                end
            end
            default: r = '0;
        endcase
        r.neg  = r.y[N-1];
        r.zero = (r.y == '0);
        return r;
    endfunction

    // Drive one operation for one cycle and queue its expected result.
    task automatic issue(input logic r, input logic [3:0] op, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic cin, input res_t exp);
        @(negedge clk);
        rst        = r;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        bus.cin    = cin;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t got, exp;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ADD_OP, 4'b0111, 4'b0001, 1'b0, res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}));
            got = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL reset[%0d] scoreboard empty", i);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL reset[%0d] got %b required %b", i, got, exp);
                end else
                    $display("reset[%0d] y=%b flags=%b", i, got.y, got[3:0]);
            end
        end
    endtask

    task automatic test_directed();
        logic [3:0] ops[14];
        logic [3:0] as[14];
        logic [3:0] bs[14];
        logic       cs[14];
        res_t       exps[14];
        res_t       got, exp;
        ops  = '{LL_SHIFT_OP, LR_SHIFT_OP, AR_SHIFT_OP, NOT_OP, AND_OP, OR_OP, XOR_OP,
                 ADD_OP, ADD_OP, SUB_OP, SUB_OP, ADD_OP, SUB_OP, LL_SHIFT_OP};
        as   = '{4'b0001, 4'b0001, 4'b1001, 4'b1000, 4'b1111, 4'b1010, 4'b1100,
                 4'b0111, 4'b1111, 4'b0011, 4'b1000, 4'b0111, 4'b0101, 4'b1011};
        bs   = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0111, 4'b0101, 4'b1010,
                 4'b0001, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        cs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        // fields: y, cout, overflow, negative, zero
        exps = '{res_t'({4'b0010, 1'b0, 1'b0, 1'b0, 1'b0}),
                 res_t'({4'b0000, 1'b1, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b1100, 1'b1, 1'b0, 1'b1, 1'b0}),
                 res_t'({4'b0111, 1'b0, 1'b0, 1'b0, 1'b0}),
                 res_t'({4'b0111, 1'b0, 1'b0, 1'b0, 1'b0}),
                 res_t'({4'b1111, 1'b0, 1'b0, 1'b1, 1'b0}),
                 res_t'({4'b0110, 1'b0, 1'b0, 1'b0, 1'b0}),
                 res_t'({4'b1000, 1'b0, 1'b1, 1'b1, 1'b0}),
                 res_t'({4'b0000, 1'b1, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b1110, 1'b0, 1'b0, 1'b1, 1'b0}),
                 res_t'({4'b0111, 1'b1, 1'b1, 1'b0, 1'b0}),
                 res_t'({4'b1000, 1'b0, 1'b1, 1'b1, 1'b0}),
                 res_t'({4'b0010, 1'b1, 1'b0, 1'b0, 1'b0}),
                 res_t'({4'b1011, 1'b0, 1'b0, 1'b1, 1'b0})};
        for (int i = 0; i < 14; i++) begin
            issue(1'b0, ops[i], as[i], bs[i], cs[i], exps[i]);
            got = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero};
            checks++;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d a=%b b=%b cin=%b got %b required %b",
                         i, ops[i], as[i], bs[i], cs[i], got, exp);
            end else
                $display("directed[%0d] op=%0d a=%b b=%b y=%b flags=%b",
                         i, ops[i], as[i], bs[i], got.y, got[3:0]);
        end
    endtask

    task automatic test_shift_bounds();
        logic [3:0] ops[6];
        logic [3:0] as[6];
        logic [3:0] bs[6];
        res_t       exps[6];
        res_t       got, exp;
        ops  = '{LL_SHIFT_OP, LR_SHIFT_OP, AR_SHIFT_OP, AR_SHIFT_OP, 4'd9, 4'd15};
        as   = '{4'b1011, 4'b1011, 4'b1011, 4'b0110, 4'b1111, 4'b1010};
        bs   = '{4'd4, 4'd7, 4'd5, 4'd9, 4'b1111, 4'b0101};
        exps = '{res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b1111, 1'b1, 1'b0, 1'b1, 1'b0}),
                 res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}),
                 res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1})};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, ops[i], as[i], bs[i], 1'b1, exps[i]);
            got = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero};
            checks++;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL bounds[%0d] op=%0d a=%b b=%b got %b required %b",
                         i, ops[i], as[i], bs[i], got, exp);
            end else
                $display("bounds[%0d] op=%0d a=%b b=%b y=%b flags=%b",
                         i, ops[i], as[i], bs[i], got.y, got[3:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op, a, b;
        logic       cin;
        res_t       got, exp;
        for (int i = 0; i < 80; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            issue(1'b0, op, a, b, cin, model(op, a, b, cin));
            got = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero};
            checks++;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%b b=%b cin=%b got %b required %b",
                         i, op, a, b, cin, got, exp);
            end else
                $display("b2b[%0d] op=%0d a=%b b=%b cin=%b y=%b flags=%b",
                         i, op, a, b, cin, got.y, got[3:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic       rs[4];
        logic [3:0] as[4];
        logic [3:0] bs[4];
        res_t       got, exp;
        rs = '{1'b0, 1'b1, 1'b0, 1'b0};
        as = '{4'b0111, 4'b1111, 4'b0011, 4'b1111};
        bs = '{4'b0001, 4'b0001, 4'b0100, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            issue(rs[i], ADD_OP, as[i], bs[i], 1'b0,
                  rs[i] ? res_t'({4'b0000, 1'b0, 1'b0, 1'b0, 1'b1})
                        : model(ADD_OP, as[i], bs[i], 1'b0));
            got = {bus.y, bus.cout, bus.overflow, bus.negative, bus.zero};
            checks++;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst[%0d] rst=%b a=%b b=%b got %b required %b",
                         i, rs[i], as[i], bs[i], got, exp);
            end else
                $display("midrst[%0d] rst=%b a=%b b=%b y=%b flags=%b",
                         i, rs[i], as[i], bs[i], got.y, got[3:0]);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.opcode = '0;
        bus.a      = '0;
        bus.b      = '0;
        bus.cin    = 1'b0;
        test_reset();
        test_directed();
        test_shift_bounds();
        test_back_to_back();
        test_mid_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu
